// File: rtl/display_pkg.sv
// Shared constants, payload types and glyph table for the multiplexed
// six-digit seven-segment clock display.
package display_pkg;

    localparam int unsigned NUM_DIGITS = 6;
    localparam int unsigned NUM_FIELDS = 3;

    localparam logic [2:0] DIG_SEC0 = 3'd0;
    localparam logic [2:0] DIG_SEC1 = 3'd1;
    localparam logic [2:0] DIG_MIN0 = 3'd2;
    localparam logic [2:0] DIG_MIN1 = 3'd3;
    localparam logic [2:0] DIG_HR0  = 3'd4;
    localparam logic [2:0] DIG_HR1  = 3'd5;

    localparam logic [1:0] FLD_SEC = 2'd0;
    localparam logic [1:0] FLD_MIN = 2'd1;
    localparam logic [1:0] FLD_HR  = 2'd2;

    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'h3F;

    // Pin-level bundle driven by the output register.
    typedef struct packed {
        logic [NUM_DIGITS-1:0] an;
        logic [6:0]            seg;
        logic                  dp;
    } disp_out_t;

    localparam disp_out_t DISP_DARK = '{an: '1, seg: SEG_OFF, dp: 1'b1};

    // Active-low {g,f,e,d,c,b,a}; anything outside 0-9 renders as a dash.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] pat;
        case (bcd)
            4'd0:    pat = 7'h40;
            4'd1:    pat = 7'h79;
            4'd2:    pat = 7'h24;
            4'd3:    pat = 7'h30;
            4'd4:    pat = 7'h19;
            4'd5:    pat = 7'h12;
            4'd6:    pat = 7'h02;
            4'd7:    pat = 7'h78;
            4'd8:    pat = 7'h00;
            4'd9:    pat = 7'h10;
            default: pat = SEG_DASH;
        endcase
        return pat;
    endfunction

    function automatic logic [1:0] field_of(input logic [2:0] dig);
        logic [1:0] fld;
        case (dig)
            DIG_SEC0, DIG_SEC1: fld = FLD_SEC;
            DIG_MIN0, DIG_MIN1: fld = FLD_MIN;
            default:            fld = FLD_HR;
        endcase
        return fld;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low seven-segment pattern.
module seg7_decode
    import display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = bcd_to_seg(bcd);
    end

endmodule

// File: rtl/seg_scan_display.sv
// Six-digit time-multiplexed seven-segment driver: digit scanning with
// anti-ghost blanking, per-field blink, hour leading-zero blanking and colon.
module seg_scan_display
    import display_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 100000,
    parameter int unsigned BLINK_DIV = 250,
    parameter int unsigned BLANK_CYC = 16
) (
    input  logic       clk,
    input  logic       sclr,
    input  logic [3:0] sec0,
    input  logic [3:0] sec1,
    input  logic [3:0] min0,
    input  logic [3:0] min1,
    input  logic [3:0] hr0,
    input  logic [3:0] hr1,
    input  logic [2:0] blink,
    input  logic       lz_sup,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int unsigned PW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [PW-1:0] pcnt;
    logic [2:0]    idx;
    logic [BW-1:0] bcnt;
    logic          phase;
    logic          first;
    logic [3:0]    hold;
    disp_out_t     out_q;

    logic          slot_end_c;
    logic          load_c;
    logic [2:0]    idx_next_c;
    logic [2:0]    src_idx_c;
    logic [3:0]    src_digit_c;
    logic [6:0]    glyph_c;
    logic          lit_c;
    logic          blank_c;
    disp_out_t     out_c;

    // Slot sequencing and digit capture source.
    always_comb begin
        slot_end_c = (pcnt == PW'(SCAN_DIV - 1));
        idx_next_c = (idx == DIG_HR1) ? DIG_SEC0 : idx + 3'd1;
        load_c     = first | slot_end_c;
        src_idx_c  = slot_end_c ? idx_next_c : idx;
    end

    always_comb begin
        case (src_idx_c)
            DIG_SEC0: src_digit_c = sec0;
            DIG_SEC1: src_digit_c = sec1;
            DIG_MIN0: src_digit_c = min0;
            DIG_MIN1: src_digit_c = min1;
            DIG_HR0:  src_digit_c = hr0;
            default:  src_digit_c = hr1;
        endcase
    end

    seg7_decode u_decode (
        .bcd (hold),
        .seg (glyph_c)
    );

    // Next pin state from the held digit; the first cycle after reset stays dark
    // because the holding register has not yet captured digit 0.
    always_comb begin
        out_c   = DISP_DARK;
        lit_c   = (pcnt >= PW'(BLANK_CYC));
        blank_c = (blink[field_of(idx)] && !phase) ||
                  ((idx == DIG_HR1) && lz_sup && (hold == 4'd0));
        if (!first) begin
            if (lit_c) begin
                out_c.an = ~(6'(1) << idx);
            end
            out_c.seg = blank_c ? SEG_OFF : glyph_c;
            out_c.dp  = !(phase && ((idx == DIG_MIN0) || (idx == DIG_HR0)));
        end
    end

    always_ff @(posedge clk or posedge sclr) begin
        if (sclr) begin
            pcnt  <= '0;
            idx   <= DIG_SEC0;
            bcnt  <= '0;
            phase <= 1'b1;
            first <= 1'b1;
            hold  <= '0;
            out_q <= DISP_DARK;
        end else begin
            first <= 1'b0;
            out_q <= out_c;
            if (load_c) begin
                hold <= src_digit_c;
            end
            if (slot_end_c) begin
                pcnt <= '0;
                idx  <= idx_next_c;
                if (bcnt == BW'(BLINK_DIV - 1)) begin
                    bcnt  <= '0;
                    phase <= ~phase;
                end else begin
                    bcnt <= bcnt + BW'(1);
                end
            end else begin
                pcnt <= pcnt + PW'(1);
            end
        end
    end

    assign an  = out_q.an;
    assign seg = out_q.seg;
    assign dp  = out_q.dp;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display with SCAN_DIV=4, BLINK_DIV=3, BLANK_CYC=1.
module tb_seg_scan_display;

    logic       clk = 1'b0;
    logic       sclr;
    logic [3:0] sec0, sec1, min0, min1, hr0, hr1;
    logic [2:0] blink;
    logic       lz_sup;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;

    int checks = 0;
    int errors = 0;
    int k = 0;
    logic [6:0] glyph [16];

    always #5 clk = ~clk;

    seg_scan_display #(
        .SCAN_DIV  (4),
        .BLINK_DIV (3),
        .BLANK_CYC (1)
    ) dut (
        .clk    (clk),
        .sclr   (sclr),
        .sec0   (sec0),
        .sec1   (sec1),
        .min0   (min0),
        .min1   (min1),
        .hr0    (hr0),
        .hr1    (hr1),
        .blink  (blink),
        .lz_sup (lz_sup),
        .an     (an),
        .seg    (seg),
        .dp     (dp)
    );

    function automatic logic [3:0] dig(input int id);
        case (id)
            0: return sec0;
            1: return sec1;
            2: return min0;
            3: return min1;
            4: return hr0;
            default: return hr1;
        endcase
    endfunction

    // Expected pins after the k-th edge since reset release (c = k-1).
    task automatic model(input int c, output logic [5:0] ea, output logic [6:0] es,
                         output logic ed);
        int n, p, id;
        logic ph;
        logic [3:0] d;
        n  = c / 4;
        p  = c % 4;
        id = n % 6;
        ph = ((n / 3) % 2) == 0;
        d  = dig(id);
        ea = (p < 1) ? 6'h3F : ~(6'd1 << id);
        es = ((blink[id/2] && !ph) || (id == 5 && lz_sup && d == 4'd0)) ? 7'h7F : glyph[d];
        ed = (ph && (id == 2 || id == 4)) ? 1'b0 : 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        k++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        sclr = 1'b1;
        repeat (2) @(negedge clk);
        sclr = 1'b0;
        k = 0;
    endtask

    task automatic set_time(input logic [3:0] h1, h0, m1, m0, s1, s0);
        hr1 = h1; hr0 = h0; min1 = m1; min0 = m0; sec1 = s1; sec0 = s0;
    endtask

    task automatic test_reset();
        sclr = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (an !== 6'h3F) begin errors++; $display("FAIL reset_an got %b want %b", an, 6'h3F); end
        checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg got %h want %h", seg, 7'h7F); end
        checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp got %b want 1", dp); end
        sclr = 1'b0;
        k = 0;
        tick();
        checks++; if (an !== 6'h3F) begin errors++; $display("FAIL first_edge_an got %b want %b", an, 6'h3F); end
    endtask

    task automatic test_scan();
        logic [6:0] sg [6];
        int c, p, id, n;
        logic ph;
        logic [5:0] ea;
        sg[0] = 7'h02; sg[1] = 7'h12; sg[2] = 7'h19;
        sg[3] = 7'h30; sg[4] = 7'h24; sg[5] = 7'h79;
        set_time(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        blink = 3'b000; lz_sup = 1'b0;
        do_reset();
        repeat (48) begin
            tick();
            c = k - 1; n = c / 4; p = c % 4; id = n % 6;
            ph = ((n / 3) % 2) == 0;
            ea = (p == 0) ? 6'h3F : ~(6'd1 << id);
            checks++;
            if (an !== ea) begin errors++; $display("FAIL scan_an c=%0d got %b want %b", c, an, ea); end
            if (p != 0) begin
                checks++;
                if (seg !== sg[id]) begin errors++; $display("FAIL scan_seg c=%0d got %h want %h", c, seg, sg[id]); end
                checks++;
                if (dp !== !(ph && (id == 2 || id == 4)))
                    begin errors++; $display("FAIL scan_dp c=%0d idx=%0d got %b", c, id, dp); end
            end
        end
    endtask

    task automatic test_blink(input logic [2:0] b);
        logic [5:0] ea; logic [6:0] es; logic ed;
        set_time(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        blink = b; lz_sup = 1'b0;
        do_reset();
        repeat (48) begin
            tick();
            model(k - 1, ea, es, ed);
            checks++;
            if (an !== ea) begin errors++; $display("FAIL blink_an b=%b c=%0d got %b want %b", b, k - 1, an, ea); end
            if (ea != 6'h3F) begin
                checks++;
                if (seg !== es) begin errors++; $display("FAIL blink_seg b=%b c=%0d got %h want %h", b, k - 1, seg, es); end
                checks++;
                if (dp !== ed) begin errors++; $display("FAIL blink_dp b=%b c=%0d got %b want %b", b, k - 1, dp, ed); end
            end
        end
    endtask

    task automatic test_blink_live();
        set_time(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        blink = 3'b000; lz_sup = 1'b0;
        do_reset();
        while (k < 18) tick();
        checks++; if (seg !== 7'h24) begin errors++; $display("FAIL live_before got %h want %h", seg, 7'h24); end
        blink = 3'b100;
        tick();
        checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL live_after got %h want %h", seg, 7'h7F); end
        checks++; if (an !== 6'b101111) begin errors++; $display("FAIL live_an got %b want %b", an, 6'b101111); end
    endtask

    task automatic test_leading_zero(input logic lz);
        logic [6:0] want5;
        set_time(4'd0, 4'd9, 4'd3, 4'd4, 4'd5, 4'd6);
        blink = 3'b000; lz_sup = lz;
        want5 = lz ? 7'h7F : 7'h40;
        do_reset();
        while (k < 4 * 4 + 2) tick();
        checks++; if (an !== 6'b101111) begin errors++; $display("FAIL lz_an4 got %b", an); end
        checks++; if (seg !== 7'h10) begin errors++; $display("FAIL lz_idx4 lz=%b got %h want %h", lz, seg, 7'h10); end
        while (k < 5 * 4 + 2) tick();
        checks++; if (an !== 6'b011111) begin errors++; $display("FAIL lz_an5 got %b", an); end
        checks++; if (seg !== want5) begin errors++; $display("FAIL lz_idx5 lz=%b got %h want %h", lz, seg, want5); end
    endtask

    task automatic test_invalid_bcd();
        set_time(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'hC);
        blink = 3'b000; lz_sup = 1'b0;
        do_reset();
        tick(); tick();
        checks++; if (an !== 6'b111110) begin errors++; $display("FAIL invalid_an got %b", an); end
        checks++; if (seg !== 7'h3F) begin errors++; $display("FAIL invalid_seg got %h want %h", seg, 7'h3F); end
        set_time(4'd1, 4'd2, 4'd3, 4'd4, 4'hF, 4'd6);
        while (k < 4 + 2) tick();
        checks++; if (seg !== 7'h7F && seg !== 7'h3F) begin errors++; $display("FAIL invalid_f got %h", seg); end
        checks++; if (seg !== 7'h3F) begin errors++; $display("FAIL invalid_seg1 got %h want %h", seg, 7'h3F); end
    endtask

    task automatic test_sample_hold();
        set_time(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        blink = 3'b000; lz_sup = 1'b0;
        do_reset();
        while (k < 3) tick();
        sec0 = 4'd8;
        tick();
        checks++; if (seg !== 7'h02) begin errors++; $display("FAIL hold_midslot got %h want %h", seg, 7'h02); end
        while (k < 6 * 4 + 2) tick();
        checks++; if (an !== 6'b111110) begin errors++; $display("FAIL hold_an got %b", an); end
        checks++; if (seg !== 7'h00) begin errors++; $display("FAIL hold_next got %h want %h", seg, 7'h00); end
    endtask

    task automatic test_reset_mid();
        set_time(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        blink = 3'b000; lz_sup = 1'b0;
        do_reset();
        while (k < 3 * 4 + 3) tick();
        checks++; if (an !== 6'b110111) begin errors++; $display("FAIL mid_pre_an got %b", an); end
        sclr = 1'b1;
        #1;
        checks++; if (an !== 6'h3F) begin errors++; $display("FAIL mid_async_an got %b want %b", an, 6'h3F); end
        @(posedge clk); #1;
        checks++; if (an !== 6'h3F) begin errors++; $display("FAIL mid_edge_an got %b want %b", an, 6'h3F); end
        checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL mid_edge_seg got %h want %h", seg, 7'h7F); end
        checks++; if (dp !== 1'b1) begin errors++; $display("FAIL mid_edge_dp got %b want 1", dp); end
        @(negedge clk);
        sclr = 1'b0;
        k = 0;
        tick();
        checks++; if (an !== 6'h3F) begin errors++; $display("FAIL mid_rel0_an got %b want %b", an, 6'h3F); end
        tick();
        checks++; if (an !== 6'b111110) begin errors++; $display("FAIL mid_rel1_an got %b want %b", an, 6'b111110); end
        checks++; if (seg !== 7'h02) begin errors++; $display("FAIL mid_rel1_seg got %h want %h", seg, 7'h02); end
    endtask

    initial begin
        glyph[0] = 7'h40; glyph[1] = 7'h79; glyph[2] = 7'h24; glyph[3] = 7'h30;
        glyph[4] = 7'h19; glyph[5] = 7'h12; glyph[6] = 7'h02; glyph[7] = 7'h78;
        glyph[8] = 7'h00; glyph[9] = 7'h10;
        for (int i = 10; i < 16; i++) glyph[i] = 7'h3F;
        set_time(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        blink = 3'b000; lz_sup = 1'b0; sclr = 1'b1;

        test_reset();
        test_scan();
        test_blink(3'b010);
        test_blink(3'b001);
        test_blink(3'b100);
        test_blink_live();
        test_leading_zero(1'b1);
        test_leading_zero(1'b0);
        test_invalid_bcd();
        test_sample_hold();
        test_reset_mid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
